cond_exec_stage: RTL and testbench

//  Execute-stage conditional unit plus E->M pipeline register. Consumes the E-stage control

---
 rtl/cond_pkg.sv | 40 ++++
 rtl/cond_exec_stage_if.sv | 47 ++++
 rtl/cond_check.sv | 39 +++
 rtl/cond_exec_stage.sv | 106 ++++++++++
 tb/tb_cond_exec_stage.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/cond_pkg.sv
// Shared types for the execute-stage conditional unit: ARM condition codes,
// NZCV bit positions and the E-stage control bundle.
package cond_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef struct packed {
    logic       pcsrc;
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_write;
    logic       branch;
    logic       brl;
    logic [1:0] flag_write;
    cond_e      cond;
  } ctrl_e_t;

endpackage

// File: rtl/cond_exec_stage_if.sv
// E-stage inputs and M-stage outputs of cond_exec_stage. EnM=0 stalls the
// E->M register and flags; FlushM=1 inserts a bubble and overrides EnM.
interface cond_exec_stage_if #(
  parameter int DATA_W = 32,
  parameter int RA_W   = 4
);
  logic              EnM;
  logic              FlushM;
  logic              PcsrcE;
  logic              RegWriteE;
  logic              MemtoRegE;
  logic              MemWriteE;
  logic              BranchE;
  logic              BrlE;
  logic [1:0]        FlagWriteE;
  logic [3:0]        CondE;
  logic [3:0]        AluFlagsE;
  logic [DATA_W-1:0] AluResultE;
  logic [DATA_W-1:0] WriteDataE;
  logic [RA_W-1:0]   WA3E;

  logic              CondExE;
  logic              BranchTakenE;
  logic [3:0]        Flags;
  logic              PcsrcM;
  logic              RegWriteM;
  logic              MemtoRegM;
  logic              MemWriteM;
  logic              BrlM;
  logic [DATA_W-1:0] AluResultM;
  logic [DATA_W-1:0] WriteDataM;
  logic [RA_W-1:0]   WA3M;

  modport master (
    output EnM, FlushM, PcsrcE, RegWriteE, MemtoRegE, MemWriteE, BranchE, BrlE,
           FlagWriteE, CondE, AluFlagsE, AluResultE, WriteDataE, WA3E,
    input  CondExE, BranchTakenE, Flags, PcsrcM, RegWriteM, MemtoRegM, MemWriteM,
           BrlM, AluResultM, WriteDataM, WA3M
  );

  modport slave (
    input  EnM, FlushM, PcsrcE, RegWriteE, MemtoRegE, MemWriteE, BranchE, BrlE,
           FlagWriteE, CondE, AluFlagsE, AluResultE, WriteDataE, WA3E,
    output CondExE, BranchTakenE, Flags, PcsrcM, RegWriteM, MemtoRegM, MemWriteM,
           BrlM, AluResultM, WriteDataM, WA3M
  );
endinterface

// File: rtl/cond_check.sv
// Combinational ARM condition evaluation of a condition field against NZCV.
module cond_check
  import cond_pkg::*;
(
  input  cond_e      i_cond,
  input  logic [3:0] i_flags,
  output logic       o_cond_ex
);

  logic w_n, w_z, w_c, w_v;

  assign w_n = i_flags[FLAG_N];
  assign w_z = i_flags[FLAG_Z];
  assign w_c = i_flags[FLAG_C];
  assign w_v = i_flags[FLAG_V];

  always_comb begin
    o_cond_ex = 1'b0;
    case (i_cond)
      COND_EQ: o_cond_ex = w_z;
      COND_NE: o_cond_ex = ~w_z;
      COND_CS: o_cond_ex = w_c;
      COND_CC: o_cond_ex = ~w_c;
      COND_MI: o_cond_ex = w_n;
      COND_PL: o_cond_ex = ~w_n;
      COND_VS: o_cond_ex = w_v;
      COND_VC: o_cond_ex = ~w_v;
      COND_HI: o_cond_ex = w_c & ~w_z;
      COND_LS: o_cond_ex = ~w_c | w_z;
      COND_GE: o_cond_ex = (w_n == w_v);
      COND_LT: o_cond_ex = (w_n != w_v);
      COND_GT: o_cond_ex = ~w_z & (w_n == w_v);
      COND_LE: o_cond_ex = w_z | (w_n != w_v);
      COND_AL: o_cond_ex = 1'b1;
      default: o_cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_exec_stage.sv
// Execute-stage conditional unit: owns the NZCV flag register, gates E-stage
// controls by the condition result and registers them into the M stage.
module cond_exec_stage
  import cond_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int RA_W   = 4
)(
  input  logic        clk,
  input  logic        reset,
  cond_exec_stage_if.slave bus
);

  ctrl_e_t           w_ctrl;
  logic              w_cond_ex;
  logic              w_flag_upd;
  logic [3:0]        r_flags;
  logic              r_pcsrc_m;
  logic              r_reg_write_m;
  logic              r_mem_to_reg_m;
  logic              r_mem_write_m;
  logic              r_brl_m;
  logic [DATA_W-1:0] r_alu_result_m;
  logic [DATA_W-1:0] r_write_data_m;
  logic [RA_W-1:0]   r_wa3_m;

  always_comb begin
    w_ctrl            = '0;
    w_ctrl.pcsrc      = bus.PcsrcE;
    w_ctrl.reg_write  = bus.RegWriteE;
    w_ctrl.mem_to_reg = bus.MemtoRegE;
    w_ctrl.mem_write  = bus.MemWriteE;
    w_ctrl.branch     = bus.BranchE;
    w_ctrl.brl        = bus.BrlE;
    w_ctrl.flag_write = bus.FlagWriteE;
    w_ctrl.cond       = cond_e'(bus.CondE);
  end

  // Condition is judged on the registered flags, never on this cycle's ALU flags.
  cond_check u_cond_check (
    .i_cond    (w_ctrl.cond),
    .i_flags   (r_flags),
    .o_cond_ex (w_cond_ex)
  );

  assign w_flag_upd = bus.EnM & w_cond_ex & ~bus.FlushM;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_flags <= '0;
    end else if (w_flag_upd) begin
      if (w_ctrl.flag_write[1]) begin
        r_flags[FLAG_N] <= bus.AluFlagsE[FLAG_N];
        r_flags[FLAG_Z] <= bus.AluFlagsE[FLAG_Z];
      end
      if (w_ctrl.flag_write[0]) begin
        r_flags[FLAG_C] <= bus.AluFlagsE[FLAG_C];
        r_flags[FLAG_V] <= bus.AluFlagsE[FLAG_V];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pcsrc_m      <= 1'b0;
      r_reg_write_m  <= 1'b0;
      r_mem_to_reg_m <= 1'b0;
      r_mem_write_m  <= 1'b0;
      r_brl_m        <= 1'b0;
      r_alu_result_m <= '0;
      r_write_data_m <= '0;
      r_wa3_m        <= '0;
    end else if (bus.FlushM) begin
      r_pcsrc_m      <= 1'b0;
      r_reg_write_m  <= 1'b0;
      r_mem_to_reg_m <= 1'b0;
      r_mem_write_m  <= 1'b0;
      r_brl_m        <= 1'b0;
      r_alu_result_m <= '0;
      r_write_data_m <= '0;
      r_wa3_m        <= '0;
    end else if (bus.EnM) begin
      r_pcsrc_m      <= w_ctrl.pcsrc & w_cond_ex;
      r_reg_write_m  <= w_ctrl.reg_write & w_cond_ex;
      r_mem_to_reg_m <= w_ctrl.mem_to_reg;
      r_mem_write_m  <= w_ctrl.mem_write & w_cond_ex;
      r_brl_m        <= w_ctrl.brl & w_cond_ex;
      r_alu_result_m <= bus.AluResultE;
      r_write_data_m <= bus.WriteDataE;
      r_wa3_m        <= bus.WA3E;
    end
  end

  assign bus.CondExE      = w_cond_ex;
  assign bus.BranchTakenE = w_ctrl.branch & w_cond_ex;
  assign bus.Flags        = r_flags;
  assign bus.PcsrcM       = r_pcsrc_m;
  assign bus.RegWriteM    = r_reg_write_m;
  assign bus.MemtoRegM    = r_mem_to_reg_m;
  assign bus.MemWriteM    = r_mem_write_m;
  assign bus.BrlM         = r_brl_m;
  assign bus.AluResultM   = r_alu_result_m;
  assign bus.WriteDataM   = r_write_data_m;
  assign bus.WA3M         = r_wa3_m;

endmodule

// File: tb/tb_cond_exec_stage.sv
// Bench for cond_exec_stage: directed scenarios then random stimulus against a
// behavioural model of the condition rules, flag register and E->M register.
module tb_cond_exec_stage;

  localparam int DATA_W = 32;
  localparam int RA_W   = 4;

  logic clk;
  logic reset;

  cond_exec_stage_if #(.DATA_W(DATA_W), .RA_W(RA_W)) bus ();

  cond_exec_stage #(.DATA_W(DATA_W), .RA_W(RA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model state ----------------
  int unsigned       n_vec;
  int unsigned       n_err;
  logic [3:0]        m_flags;
  logic [4:0]        m_ctl;      // {Pcsrc, RegWrite, MemtoReg, MemWrite, Brl}
  logic [DATA_W-1:0] m_alu;
  logic [DATA_W-1:0] m_wd;
  logic [RA_W-1:0]   m_wa3;
  logic [4:0]        exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ARM decoding: cond[3:1] picks a base test, cond[0] inverts it; 1111 never passes.
  function automatic logic model_cond(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v, base;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (cond[3:1])
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = c && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    if (cond == 4'b1111) return 1'b0;
    return cond[0] ? !base : base;
  endfunction

  task automatic model_reset();
    m_flags = '0; m_ctl = '0; m_alu = '0; m_wd = '0; m_wa3 = '0;
    exp_q.delete();
  endtask

  // Applies one clock edge worth of behaviour using the inputs present at the edge.
  task automatic model_update(input logic ce);
    if (bus.FlushM) begin
      m_ctl = '0; m_alu = '0; m_wd = '0; m_wa3 = '0;
    end else if (bus.EnM) begin
      m_ctl = {bus.PcsrcE & ce, bus.RegWriteE & ce, bus.MemtoRegE, bus.MemWriteE & ce, bus.BrlE & ce};
      m_alu = bus.AluResultE; m_wd = bus.WriteDataE; m_wa3 = bus.WA3E;
    end
    if (bus.EnM && ce && !bus.FlushM) begin
      if (bus.FlagWriteE[1]) m_flags[3:2] = bus.AluFlagsE[3:2];
      if (bus.FlagWriteE[0]) m_flags[1:0] = bus.AluFlagsE[1:0];
    end
    exp_q.push_back(m_ctl);
  endtask

  task automatic check_regs(input string tag);
    logic [4:0] exp_ctl;
    exp_ctl = (exp_q.size() > 0) ? exp_q.pop_front() : m_ctl;
    check_eq({tag, "_flags"}, bus.Flags, m_flags);
    check_eq({tag, "_ctl"}, {bus.PcsrcM, bus.RegWriteM, bus.MemtoRegM, bus.MemWriteM, bus.BrlM}, exp_ctl);
    check_eq({tag, "_alu"}, bus.AluResultM, m_alu);
    check_eq({tag, "_wd"}, bus.WriteDataM, m_wd);
    check_eq({tag, "_wa3"}, bus.WA3M, m_wa3);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    bus.EnM = 1'b1; bus.FlushM = 1'b0;
    bus.PcsrcE = 1'b0; bus.RegWriteE = 1'b0; bus.MemtoRegE = 1'b0; bus.MemWriteE = 1'b0;
    bus.BranchE = 1'b0; bus.BrlE = 1'b0; bus.FlagWriteE = 2'b00; bus.CondE = 4'b0000;
    bus.AluFlagsE = 4'b0000; bus.AluResultE = '0; bus.WriteDataE = '0; bus.WA3E = '0;
  endtask

  // Inputs are already driven; checks combinational outputs, clocks, checks registers.
  task automatic cycle(input string tag);
    logic ce;
    #1;
    ce = model_cond(bus.CondE, m_flags);
    check_eq({tag, "_condex"}, bus.CondExE, ce);
    check_eq({tag, "_brtaken"}, bus.BranchTakenE, bus.BranchE & ce);
    @(posedge clk);
    model_update(ce);
    #1;
    check_regs(tag);
  endtask

  task automatic set_flags(input logic [3:0] f);
    drive_idle();
    bus.FlagWriteE = 2'b11; bus.CondE = 4'b1110; bus.AluFlagsE = f;
    cycle("setf");
  endtask

  task automatic async_reset(input string tag);
    reset = 1'b0;
    #1;
    model_reset();
    check_eq({tag, "_flags"}, bus.Flags, 4'b0000);
    check_eq({tag, "_ctl"}, {bus.PcsrcM, bus.RegWriteM, bus.MemtoRegM, bus.MemWriteM, bus.BrlM}, 5'b0);
    check_eq({tag, "_alu"}, bus.AluResultM, '0);
    check_eq({tag, "_wa3"}, bus.WA3M, '0);
    #1;
    reset = 1'b1;
  endtask

  task automatic drive_random();
    bus.EnM        = ($urandom_range(0, 3) != 0);
    bus.FlushM     = ($urandom_range(0, 7) == 0);
    bus.PcsrcE     = 1'($urandom);
    bus.RegWriteE  = 1'($urandom);
    bus.MemtoRegE  = 1'($urandom);
    bus.MemWriteE  = 1'($urandom);
    bus.BranchE    = 1'($urandom);
    bus.BrlE       = 1'($urandom);
    bus.FlagWriteE = 2'($urandom);
    bus.CondE      = 4'($urandom_range(0, 15));
    bus.AluFlagsE  = 4'($urandom);
    bus.AluResultE = $urandom;
    bus.WriteDataE = $urandom;
    bus.WA3E       = 4'($urandom);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    n_vec = 0; n_err = 0;
    model_reset();
    reset = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_flags", bus.Flags, 4'b0000);
    check_eq("rst_ctl", {bus.PcsrcM, bus.RegWriteM, bus.MemtoRegM, bus.MemWriteM, bus.BrlM}, 5'b0);
    reset = 1'b1;

    // Scenario 2: EQ passes with Z set, NE fails.
    set_flags(4'b0100);
    drive_idle(); bus.CondE = 4'b0000; bus.RegWriteE = 1'b1; bus.WA3E = 4'd3;
    #1 check_eq("t2_eq_condex", bus.CondExE, 1'b1);
    cycle("t2_eq");
    check_eq("t2_eq_regw", bus.RegWriteM, 1'b1);
    check_eq("t2_eq_wa3", bus.WA3M, 4'd3);
    bus.CondE = 4'b0001;
    cycle("t2_ne");
    check_eq("t2_ne_regw", bus.RegWriteM, 1'b0);

    // Scenario 3: set N,V then LT fails / GE passes on the very next cycle.
    drive_idle(); bus.FlagWriteE = 2'b11; bus.CondE = 4'b1110; bus.AluFlagsE = 4'b1001;
    cycle("t3_set");
    check_eq("t3_flags", bus.Flags, 4'b1001);
    drive_idle(); bus.CondE = 4'b1011;
    #1 check_eq("t3_lt", bus.CondExE, 1'b0);
    bus.CondE = 4'b1010;
    #1 check_eq("t3_ge", bus.CondExE, 1'b1);
    cycle("t3_ge");

    // Scenario 4: only C,V update.
    set_flags(4'b0100);
    drive_idle(); bus.FlagWriteE = 2'b01; bus.CondE = 4'b1110; bus.AluFlagsE = 4'b1011;
    cycle("t4");
    check_eq("t4_flags", bus.Flags, 4'b0111);

    // Scenario 5: HI branch.
    set_flags(4'b0010);
    drive_idle(); bus.BranchE = 1'b1; bus.CondE = 4'b1000;
    #1 check_eq("t5_hi_taken", bus.BranchTakenE, 1'b1);
    cycle("t5_a");
    set_flags(4'b0110);
    drive_idle(); bus.BranchE = 1'b1; bus.CondE = 4'b1000;
    #1 check_eq("t5_hi_not", bus.BranchTakenE, 1'b0);
    cycle("t5_b");

    // Scenario 6: stall, then flush with enable, then NV.
    drive_idle(); bus.RegWriteE = 1'b1; bus.MemWriteE = 1'b1; bus.CondE = 4'b1110;
    bus.AluResultE = 32'hCAFE_F00D; bus.WA3E = 4'd9;
    cycle("t6_load");
    drive_idle(); bus.EnM = 1'b0; bus.FlagWriteE = 2'b11; bus.CondE = 4'b1110;
    bus.AluFlagsE = 4'b1111; bus.RegWriteE = 1'b0; bus.AluResultE = 32'h1234_5678;
    cycle("t6_stall1");
    cycle("t6_stall2");
    check_eq("t6_hold_alu", bus.AluResultM, 32'hCAFE_F00D);
    check_eq("t6_hold_flags", bus.Flags, 4'b0110);
    bus.EnM = 1'b1; bus.FlushM = 1'b1;
    cycle("t6_flush");
    check_eq("t6_flush_regw", bus.RegWriteM, 1'b0);
    check_eq("t6_flush_flags", bus.Flags, 4'b0110);
    drive_idle(); bus.CondE = 4'b1111; bus.RegWriteE = 1'b1;
    #1 check_eq("t6_nv", bus.CondExE, 1'b0);
    cycle("t6_nv");

    // Scenario 1: async reset with M loaded, no clock edge involved.
    drive_idle(); bus.RegWriteE = 1'b1; bus.CondE = 4'b1110; bus.AluResultE = 32'hA5A5_5A5A;
    bus.WA3E = 4'd7; bus.FlagWriteE = 2'b11; bus.AluFlagsE = 4'b1010;
    cycle("t1_load");
    async_reset("t1_rst");

    // Random phase, with occasional asynchronous resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 63) == 0) async_reset("rnd_rst");
      drive_random();
      cycle("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
